onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word address width of memory port.
REQ-002 Parameter DATA_W, default 32, data width; BE_W = DATA_W/8 (4).
REQ-003 Parameter LOCK_MAX, default 16, max consecutive locked grants to one port.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 m0_read, m0_write  in  1 each  port-0 Avalon-MM read/write request.
REQ-007 m0_address  in  ADDR_W; m0_byteenable in BE_W; m0_writedata in DATA_W  port-0 command.
REQ-008 m0_lock  in  1  port-0 arbiterlock: request to keep grant for next transfer.
REQ-009 m0_waitrequest  out  1; m0_readdata out DATA_W; m0_readdatavalid out 1  port-0 response.
REQ-010 m1_* ports  identical set to REQ-006..009 for port 1.
REQ-011 mem_chipselect, mem_write  out  1 each  memory port strobes.
REQ-012 mem_address out ADDR_W; mem_byteenable out BE_W; mem_writedata out DATA_W  memory command.
REQ-013 mem_readdata  in  DATA_W  memory read data, valid one clk after read address presented.

Function
REQ-014 Port request SHALL be read|write; read and write together SHALL be treated as write, read ignored.
REQ-015 Grant SHALL be computed combinationally each cycle from requests and registered arbiter state; one port max.
REQ-016 Winner's command SHALL drive memory port same cycle: mem_chipselect=1, mem_write=winner write, address/byteenable/writedata from winner.
REQ-017 No winner: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata=0.
REQ-018 mX_waitrequest SHALL be 1 iff port X requests and is not granted; acceptance = request & ~waitrequest.
REQ-019 Single requester SHALL be granted immediately (zero-wait), every cycle it requests.
REQ-020 Both requesting, no active lock: grant SHALL go to port other than last_grant (round-robin).
REQ-021 last_grant SHALL update to the accepted port on every acceptance; unchanged in idle cycles.
REQ-022 Accepted transfer with mX_lock=1: port X SHALL win next cycle if it requests, regardless of round-robin.
REQ-023 lock_cnt SHALL increment per consecutive locked acceptance by same port; at lock_cnt=LOCK_MAX lock SHALL be ignored for one arbitration and round-robin applies.
REQ-024 lock_cnt SHALL clear when holder accepts with lock=0, holder does not request, or other port is granted.
REQ-025 Accepted read SHALL set registered rd_pend=1, rd_port=X; next cycle mX_readdatavalid=1 exactly one cycle.
REQ-026 m0_readdata and m1_readdata SHALL both equal mem_readdata combinationally; valid only with own readdatavalid.
REQ-027 Back-to-back reads (either port, alternating or same) SHALL be accepted every cycle with one readdatavalid per read, in order.
REQ-028 Writes SHALL complete on acceptance; no response strobe.
REQ-029 Read accepted in cycle T followed by write in T+1 SHALL both proceed; readdatavalid in T+1 reflects T read.

Reset
REQ-030 On reset: last_grant=1 (port 0 wins first tie), lock_cnt=0, rd_pend=0, all readdatavalid=0.
REQ-031 Reset asserted with read pending SHALL drop it; no readdatavalid after reset release.
REQ-032 While reset asserted mem_chipselect and mem_write SHALL be 0 and all waitrequest=1 for requesting ports.

Structure
REQ-033 Package onchip_mem_arb_pkg SHALL hold ADDR_W/DATA_W/LOCK_MAX defaults, port-index type, lock-counter width constant.
REQ-034 Sub-module onchip_mem_arb_grant SHALL contain last_grant, lock_cnt and grant logic; top holds muxing and read-valid register.

Verification
REQ-035 Reset, then m0 and m1 read addr 0x10/0x20 same cycle -> m0 granted, m1 waitrequest=1; next cycle m1 granted, m0_readdatavalid=1.
REQ-036 Both ports request continuously 8 cycles -> grants alternate 0,1,0,1...; each port accepted 4 times.
REQ-037 m0 writes 0xDEADBEEF, byteenable 0x3, addr 0x05; m1 reads 0x05 next cycle -> m1_readdata low 16 bits 0xBEEF.
REQ-038 m0_lock=1 with both requesting continuously, LOCK_MAX=16 -> m0 granted 17 consecutive cycles, then m1 granted once.
REQ-039 Reset asserted cycle after accepted read -> no readdatavalid on either port, mem_chipselect=0 during reset.
REQ-040 Random two-port traffic vs reference memory model -> all readdata match, no lost or duplicated readdatavalid.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// Shared defaults and types for the two-port on-chip memory arbiter.
package onchip_mem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int LOCK_MAX_DEF = 16;

    // Wide enough for any LOCK_MAX up to 255
    localparam int LOCK_CNT_W   = 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

endpackage

// File: rtl/onchip_mem_arb_grant.sv
// Round-robin grant with bounded arbiterlock; holds last_grant and lock counter state.
module onchip_mem_arb_grant
    import onchip_mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic lock0_i,
    input  logic lock1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    port_t                 last_q, last_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic  any_grant;
    logic  lock_act;
    logic  win_lock;
    port_t win;

    always_comb begin
        lock_act  = lock_vld_q && (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX));
        any_grant = (req0_i | req1_i) & ~reset;

        win = PORT0;
        if (req0_i && req1_i) begin
            // A live lock keeps the previous holder; otherwise alternate
            win = lock_act ? last_q : ((last_q == PORT0) ? PORT1 : PORT0);
        end else if (req1_i) begin
            win = PORT1;
        end

        gnt0_o   = any_grant && (win == PORT0);
        gnt1_o   = any_grant && (win == PORT1);
        win_lock = (win == PORT0) ? lock0_i : lock1_i;

        last_d     = any_grant ? win : last_q;
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
        if (any_grant && win_lock) begin
            lock_vld_d = 1'b1;
            // Count only locked grants that were themselves won through the lock
            if (lock_act && (win == last_q)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= PORT1;
            lock_vld_q <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter onto a single on-chip memory with one-cycle read latency.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic  req0, req1;
    logic  gnt0, gnt1;
    logic  rd_pend_q, rd_pend_d;
    port_t rd_port_q, rd_port_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    onchip_mem_arb_grant #(
        .LOCK_MAX (LOCK_MAX)
    ) u_grant (
        .clk     (clk),
        .reset   (reset),
        .req0_i  (req0),
        .req1_i  (req1),
        .lock0_i (m0_lock),
        .lock1_i (m1_lock),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt0) begin
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (gnt1) begin
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // A grant with write deasserted is a read (write wins when both are set)
    assign rd_pend_d = (gnt0 & ~m0_write) | (gnt1 & ~m1_write);
    assign rd_port_d = gnt1 ? PORT1 : PORT0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign m0_readdatavalid = rd_pend_q && (rd_port_q == PORT0);
    assign m1_readdatavalid = rd_pend_q && (rd_port_q == PORT1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a byte-enabled memory model on the memory port.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_read, m0_write, m0_lock;
    logic [7:0]  m0_address;
    logic [3:0]  m0_byteenable;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest, m0_readdatavalid;
    logic [31:0] m0_readdata;
    logic        m1_read, m1_write, m1_lock;
    logic [7:0]  m1_address;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [31:0] m1_readdata;
    logic        mem_chipselect, mem_write;
    logic [7:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] mem [256];

    int vec_cnt = 0;
    int err_cnt = 0;

    onchip_mem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .LOCK_MAX (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents after reset: word i holds 0xA50000ii
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | 32'(k);
            mem_readdata <= 32'h0;
        end else begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= mem[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    endtask

    logic [7:0]  w0s, w1s;
    logic [18:0] lk1s, lk0s;
    int          rc0, rc1;

    initial begin
        reset = 1'b0;
        idle_all();
        #2 reset = 1'b1;
        m0_read = 1;

        // Reset state while port 0 requests
        @(negedge clk);
        chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("rst_wr", {31'b0, mem_write}, 32'd0);
        chk("rst_wait0", {31'b0, m0_waitrequest}, 32'd1);
        chk("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);

        // Simultaneous reads: port 0 wins first tie
        nxt(); reset = 0;
        m0_read = 1; m0_address = 8'h10;
        m1_read = 1; m1_address = 8'h20;
        @(negedge clk);
        chk("tie_wait0", {31'b0, m0_waitrequest}, 32'd0);
        chk("tie_wait1", {31'b0, m1_waitrequest}, 32'd1);
        chk("tie_addr", {24'b0, mem_address}, 32'h10);
        chk("tie_cs", {31'b0, mem_chipselect}, 32'd1);
        nxt(); m0_read = 0;
        @(negedge clk);
        chk("tie2_wait1", {31'b0, m1_waitrequest}, 32'd0);
        chk("tie2_addr", {24'b0, mem_address}, 32'h20);
        chk("tie2_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
        chk("tie2_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        chk("tie2_data0", m0_readdata, 32'hA500_0010);
        nxt(); idle_all();
        @(negedge clk);
        chk("tie3_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
        chk("tie3_data1", m1_readdata, 32'hA500_0020);
        chk("idle_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("idle_addr", {24'b0, mem_address}, 32'd0);

        // Both ports read continuously for 8 cycles
        w0s = 0; w1s = 0; rc0 = 0; rc1 = 0;
        for (int i = 0; i < 8; i++) begin
            nxt();
            m0_read = 1; m0_address = 8'(i);
            m1_read = 1; m1_address = 8'(i);
            @(negedge clk);
            w0s[i] = ~m0_waitrequest;
            w1s[i] = ~m1_waitrequest;
            if (m0_readdatavalid) begin
                rc0++;
                chk("b2b_data0", m0_readdata, 32'hA500_0000 | 32'(i - 1));
            end
            if (m1_readdatavalid) begin
                rc1++;
                chk("b2b_data1", m1_readdata, 32'hA500_0000 | 32'(i - 1));
            end
        end
        nxt(); idle_all();
        @(negedge clk);
        if (m0_readdatavalid) rc0++;
        if (m1_readdatavalid) begin
            rc1++;
            chk("b2b_data1_last", m1_readdata, 32'hA500_0007);
        end
        chk("rr_grants0", {24'b0, w0s}, 32'h55);
        chk("rr_grants1", {24'b0, w1s}, 32'hAA);
        chk("rr_rdv_cnt0", 32'(rc0), 32'd4);
        chk("rr_rdv_cnt1", 32'(rc1), 32'd4);

        // Partial write then read-back; read followed by write; read+write treated as write
        nxt();
        m0_write = 1; m0_address = 8'h05; m0_byteenable = 4'h3; m0_writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_cs", {31'b0, mem_chipselect}, 32'd1);
        chk("wr_we", {31'b0, mem_write}, 32'd1);
        chk("wr_be", {28'b0, mem_byteenable}, 32'h3);
        chk("wr_data", mem_writedata, 32'hDEAD_BEEF);
        nxt(); idle_all();
        m1_read = 1; m1_address = 8'h05;
        @(negedge clk);
        chk("rd5_wait1", {31'b0, m1_waitrequest}, 32'd0);
        chk("rd5_we", {31'b0, mem_write}, 32'd0);
        nxt(); idle_all();
        m0_write = 1; m0_address = 8'h06; m0_byteenable = 4'hF; m0_writedata = 32'h1122_3344;
        @(negedge clk);
        chk("rd5_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
        chk("rd5_low16", {16'b0, m1_readdata[15:0]}, 32'h0000_BEEF);
        chk("rd5_data", m1_readdata, 32'hA500_BEEF);
        chk("rw_we", {31'b0, mem_write}, 32'd1);
        nxt(); idle_all();
        m1_read = 1; m1_write = 1; m1_address = 8'h07; m1_byteenable = 4'hF; m1_writedata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rdwr_we", {31'b0, mem_write}, 32'd1);
        chk("rdwr_data", mem_writedata, 32'hCAFE_F00D);
        nxt(); idle_all();
        m1_read = 1; m1_address = 8'h06;
        @(negedge clk);
        chk("rdwr_no_rdv", {31'b0, m1_readdatavalid}, 32'd0);
        nxt(); m1_address = 8'h07;
        @(negedge clk);
        chk("rd6_data", m1_readdata, 32'h1122_3344);
        chk("rd6_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
        nxt(); idle_all();
        @(negedge clk);
        chk("rd7_data", m1_readdata, 32'hCAFE_F00D);

        // Port 0 holds lock with both requesting: 17 grants, then port 1 once
        lk0s = 0; lk1s = 0;
        for (int i = 0; i < 19; i++) begin
            nxt();
            m0_read = 1; m0_lock = 1; m0_address = 8'(i);
            m1_read = 1; m1_address = 8'h40;
            @(negedge clk);
            lk0s[i] = ~m0_waitrequest;
            lk1s[i] = ~m1_waitrequest;
        end
        chk("lock_m1_seq", {13'b0, lk1s}, 32'h0002_0000);
        chk("lock_m0_seq", {13'b0, lk0s}, 32'h0005_FFFF);

        // Reset right after an accepted read drops the pending response
        nxt(); idle_all();
        nxt();
        m0_read = 1; m0_address = 8'h10;
        @(negedge clk);
        chk("prerst_wait0", {31'b0, m0_waitrequest}, 32'd0);
        nxt(); reset = 1;
        @(negedge clk);
        chk("inrst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        chk("inrst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        chk("inrst_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("inrst_wait0", {31'b0, m0_waitrequest}, 32'd1);
        nxt(); reset = 0; idle_all();
        @(negedge clk);
        chk("postrst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        nxt();
        m0_read = 1; m0_address = 8'h01;
        m1_read = 1; m1_address = 8'h02;
        @(negedge clk);
        chk("postrst_tie0", {31'b0, m0_waitrequest}, 32'd0);
        chk("postrst_tie1", {31'b0, m1_waitrequest}, 32'd1);
        nxt(); idle_all();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
